gb_cpu_irq_ctrl: RTL and testbench



---
 rtl/gb_cpu_irq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gb_cpu_irq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gb_cpu_irq_ctrl
// Purpose  : GameBoy CPU interrupt flags, IME latch, HALT wake-up and the
//            5-M-cycle interrupt dispatch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module gb_cpu_irq_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'h40,
    parameter int         NUM_IRQ  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m_tick_i,
    input  logic               instr_boundary_i,
    input  logic [NUM_IRQ-1:0] ie_i,
    input  logic [NUM_IRQ-1:0] if_set_i,
    input  logic               if_wr_en_i,
    input  logic [NUM_IRQ-1:0] if_wr_data_i,
    input  logic               ei_i,
    input  logic               di_i,
    input  logic               reti_i,
    input  logic               halt_i,
    output logic [NUM_IRQ-1:0] if_o,
    output logic               ime_o,
    output logic               halted_o,
    output logic               busy_o,
    output logic               sp_dec_o,
    output logic               push_hi_o,
    output logic               push_lo_o,
    output logic               load_pc_o,
    output logic [7:0]         vector_o
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_HALT    = 3'd1;
    localparam logic [2:0] S_D_WAIT  = 3'd2;
    localparam logic [2:0] S_D_SPDEC = 3'd3;
    localparam logic [2:0] S_D_PUSHH = 3'd4;
    localparam logic [2:0] S_D_PUSHL = 3'd5;
    localparam logic [2:0] S_D_JUMP  = 3'd6;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [NUM_IRQ-1:0] if_flags;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               take_sel;
    logic               enter_dispatch;
    logic               ime_promote;
    logic               ime;
    logic               ime_pending;
    logic [7:0]         vec_sel;

    assign pend = ie_i & if_flags;

    // Descending scan so the lowest set bit (highest priority) wins.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx   = IDX_W'(i);
                sel_valid = 1'b1;
            end
        end
    end

    assign take_sel = m_tick_i && (state == S_D_PUSHH);
    assign clr_mask = (take_sel && sel_valid)
                    ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << sel_idx) : '0;
    assign vec_sel  = VEC_BASE + 8'({sel_idx, 3'b000});

    always_comb begin
        state_nxt = state;
        if (m_tick_i) begin
            case (state)
                S_RUN: begin
                    if (instr_boundary_i) begin
                        if (ime && (|pend))
                            state_nxt = S_D_WAIT;
                        else if (halt_i)
                            state_nxt = S_HALT;
                    end
                end
                S_HALT: begin
                    if (|pend)
                        state_nxt = ime ? S_D_WAIT : S_RUN;
                end
                S_D_WAIT:  state_nxt = S_D_SPDEC;
                S_D_SPDEC: state_nxt = S_D_PUSHH;
                S_D_PUSHH: state_nxt = S_D_PUSHL;
                S_D_PUSHL: state_nxt = S_D_JUMP;
                S_D_JUMP:  state_nxt = S_RUN;
                default:   state_nxt = S_RUN;
            endcase
        end
    end

    assign enter_dispatch = (state_nxt == S_D_WAIT) && (state != S_D_WAIT);
    // The boundary's dispatch check above uses the old IME, so EI's enable
    // lands only after the following instruction has executed.
    assign ime_promote    = (state == S_RUN) && instr_boundary_i && ime_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            halted_o  <= 1'b0;
            busy_o    <= 1'b0;
            sp_dec_o  <= 1'b0;
            push_hi_o <= 1'b0;
            push_lo_o <= 1'b0;
            load_pc_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            halted_o  <= (state_nxt == S_HALT);
            busy_o    <= (state_nxt != S_RUN) && (state_nxt != S_HALT);
            sp_dec_o  <= (state_nxt == S_D_SPDEC) || (state_nxt == S_D_PUSHH);
            push_hi_o <= (state_nxt == S_D_PUSHH);
            push_lo_o <= (state_nxt == S_D_PUSHL);
            load_pc_o <= (state_nxt == S_D_JUMP);
        end
    end

    // A peripheral set always wins over a same-cycle write or dispatch clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            if_flags <= '0;
        else
            if_flags <= ((if_wr_en_i ? if_wr_data_i : if_flags) & ~clr_mask) | if_set_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vector_o <= 8'h00;
        else if (take_sel)
            vector_o <= sel_valid ? vec_sel : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ime         <= 1'b0;
            ime_pending <= 1'b0;
        end else if (m_tick_i) begin
            if (di_i || enter_dispatch) begin
                ime         <= 1'b0;
                ime_pending <= 1'b0;
            end else begin
                if (ei_i)
                    ime_pending <= 1'b1;
                else if (ime_promote)
                    ime_pending <= 1'b0;
                if (reti_i || ime_promote)
                    ime <= 1'b1;
            end
        end
    end

    assign if_o  = if_flags;
    assign ime_o = ime;

endmodule
`default_nettype wire

// File: tb/tb_gb_cpu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_cpu_irq_ctrl
// Purpose  : Directed self-checking bench for gb_cpu_irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_cpu_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_tick_i;
    logic       instr_boundary_i;
    logic [4:0] ie_i;
    logic [4:0] if_set_i;
    logic       if_wr_en_i;
    logic [4:0] if_wr_data_i;
    logic       ei_i, di_i, reti_i, halt_i;
    logic [4:0] if_o;
    logic       ime_o, halted_o, busy_o, sp_dec_o, push_hi_o, push_lo_o, load_pc_o;
    logic [7:0] vector_o;

    int n_chk  = 0;
    int n_pass = 0;

    gb_cpu_irq_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_tick_i         (m_tick_i),
        .instr_boundary_i (instr_boundary_i),
        .ie_i             (ie_i),
        .if_set_i         (if_set_i),
        .if_wr_en_i       (if_wr_en_i),
        .if_wr_data_i     (if_wr_data_i),
        .ei_i             (ei_i),
        .di_i             (di_i),
        .reti_i           (reti_i),
        .halt_i           (halt_i),
        .if_o             (if_o),
        .ime_o            (ime_o),
        .halted_o         (halted_o),
        .busy_o           (busy_o),
        .sp_dec_o         (sp_dec_o),
        .push_hi_o        (push_hi_o),
        .push_lo_o        (push_lo_o),
        .load_pc_o        (load_pc_o),
        .vector_o         (vector_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_pulses();
        m_tick_i         = 1'b0;
        instr_boundary_i = 1'b0;
        if_set_i         = '0;
        if_wr_en_i       = 1'b0;
        ei_i             = 1'b0;
        di_i             = 1'b0;
        reti_i           = 1'b0;
        halt_i           = 1'b0;
    endtask

    // One M-cycle: a ticking clk followed by a non-ticking clk.
    task automatic step();
        m_tick_i = 1'b1;
        @(posedge clk); #1;
        clear_pulses();
        @(posedge clk); #1;
    endtask

    // A single clk without an M-cycle tick.
    task automatic idle();
        @(posedge clk); #1;
        clear_pulses();
    endtask

    task automatic strobes(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, busy_o, sp_dec_o, push_hi_o, push_lo_o, load_pc_o}, {27'd0, exp});
    endtask

    initial begin
        clear_pulses();
        ie_i         = '0;
        if_wr_data_i = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_if", {27'd0, if_o}, 32'h0);
        chk("reset_ime", {31'd0, ime_o}, 32'h0);
        chk("reset_halted", {31'd0, halted_o}, 32'h0);
        strobes("reset_strobes", 5'b00000);
        chk("reset_vector", {24'd0, vector_o}, 32'h0);
        rst_n = 1'b1;
        idle();

        // Basic VBlank dispatch
        ie_i = 5'h01;
        reti_i = 1'b1; step();
        chk("reti_ime", {31'd0, ime_o}, 32'h1);
        if_set_i = 5'h01; idle();
        chk("if_set_visible", {27'd0, if_o}, 32'h01);
        instr_boundary_i = 1'b1; step();
        strobes("m1_wait", 5'b10000);
        chk("m1_ime_cleared", {31'd0, ime_o}, 32'h0);
        step(); strobes("m2_spdec", 5'b11000);
        step(); strobes("m3_pushh", 5'b11100);
        step(); strobes("m4_pushl", 5'b10010);
        chk("m4_if_cleared", {27'd0, if_o}, 32'h0);
        step(); strobes("m5_jump", 5'b10001);
        chk("m5_vector", {24'd0, vector_o}, 32'h40);
        step(); strobes("run_after", 5'b00000);

        // Priority: bit 2 before bit 4, RETI re-enables
        ie_i = 5'h1F; if_set_i = 5'h14; idle();
        reti_i = 1'b1; step();
        instr_boundary_i = 1'b1; step();
        step(); step(); step();
        chk("prio_if_left", {27'd0, if_o}, 32'h10);
        step(); chk("prio_vector_50", {24'd0, vector_o}, 32'h50);
        step();
        reti_i = 1'b1; step();
        chk("prio_reti_ime", {31'd0, ime_o}, 32'h1);
        instr_boundary_i = 1'b1; step();
        chk("prio2_busy", {31'd0, busy_o}, 32'h1);
        step(); step(); step(); step();
        chk("prio_vector_60", {24'd0, vector_o}, 32'h60);
        chk("prio_if_empty", {27'd0, if_o}, 32'h0);
        step();

        // EI delay by one instruction
        ie_i = 5'h01; if_set_i = 5'h01; idle();
        ei_i = 1'b1; instr_boundary_i = 1'b1; step();
        chk("ei_k_ime", {31'd0, ime_o}, 32'h0);
        instr_boundary_i = 1'b1; step();
        chk("ei_k1_nodispatch", {31'd0, busy_o}, 32'h0);
        chk("ei_k1_ime", {31'd0, ime_o}, 32'h1);
        instr_boundary_i = 1'b1; step();
        chk("ei_k2_dispatch", {31'd0, busy_o}, 32'h1);
        step(); step(); step(); step();
        chk("ei_vector", {24'd0, vector_o}, 32'h40);
        step();
        ei_i = 1'b1; instr_boundary_i = 1'b1; step();
        di_i = 1'b1; step();
        instr_boundary_i = 1'b1; step();
        chk("ei_di_ime", {31'd0, ime_o}, 32'h0);

        // HALT wake without IME
        ie_i = 5'h04;
        halt_i = 1'b1; instr_boundary_i = 1'b1; step();
        chk("halt_enter", {31'd0, halted_o}, 32'h1);
        step(); chk("halt_stays", {31'd0, halted_o}, 32'h1);
        if_set_i = 5'h04; idle();
        chk("halt_no_tick_yet", {31'd0, halted_o}, 32'h1);
        step();
        chk("halt_wake", {31'd0, halted_o}, 32'h0);
        chk("halt_wake_busy", {31'd0, busy_o}, 32'h0);
        step();
        chk("halt_wake_busy2", {31'd0, busy_o}, 32'h0);
        chk("halt_if_kept", {27'd0, if_o}, 32'h04);

        // HALT wake with IME
        if_wr_en_i = 1'b1; if_wr_data_i = 5'h00; idle();
        chk("if_write_clear", {27'd0, if_o}, 32'h0);
        reti_i = 1'b1; step();
        halt_i = 1'b1; instr_boundary_i = 1'b1; step();
        chk("halt2_enter", {31'd0, halted_o}, 32'h1);
        if_set_i = 5'h04; idle();
        step();
        chk("halt2_left", {31'd0, halted_o}, 32'h0);
        chk("halt2_busy", {31'd0, busy_o}, 32'h1);
        step(); step(); step(); step();
        chk("halt2_vector", {24'd0, vector_o}, 32'h50);
        step();

        // Dispatch beats HALT at the same boundary
        reti_i = 1'b1; ie_i = 5'h01; if_set_i = 5'h01; step();
        halt_i = 1'b1; instr_boundary_i = 1'b1; step();
        chk("halt_vs_irq_busy", {31'd0, busy_o}, 32'h1);
        chk("halt_vs_irq_halted", {31'd0, halted_o}, 32'h0);
        step(); step(); step(); step(); step();

        // IE cleared during the high-byte push
        reti_i = 1'b1; ie_i = 5'h02; if_set_i = 5'h02; step();
        instr_boundary_i = 1'b1; step();
        step(); step();
        ie_i = 5'h00;
        step();
        chk("ie0_if_unchanged", {27'd0, if_o}, 32'h02);
        step();
        chk("ie0_vector", {24'd0, vector_o}, 32'h00);
        chk("ie0_load_pc", {31'd0, load_pc_o}, 32'h1);
        step();

        // Set on the latched bit beats the dispatch clear
        if_wr_en_i = 1'b1; if_wr_data_i = 5'h00; idle();
        reti_i = 1'b1; ie_i = 5'h01; if_set_i = 5'h01; step();
        instr_boundary_i = 1'b1; step();
        step(); step();
        if_set_i = 5'h01; step();
        chk("set_beats_clear", {27'd0, if_o}, 32'h01);
        step();
        chk("set_beats_vector", {24'd0, vector_o}, 32'h40);
        step();

        // Asynchronous reset in D_PUSHL
        reti_i = 1'b1; step();
        instr_boundary_i = 1'b1; step();
        step(); step(); step();
        chk("pre_reset_pushl", {31'd0, push_lo_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        strobes("async_reset_strobes", 5'b00000);
        chk("async_reset_if", {27'd0, if_o}, 32'h0);
        chk("async_reset_ime", {31'd0, ime_o}, 32'h0);
        chk("async_reset_vector", {24'd0, vector_o}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        if_set_i = 5'h01; idle();
        instr_boundary_i = 1'b1; step();
        chk("post_reset_nodispatch", {31'd0, busy_o}, 32'h0);
        step();
        strobes("post_reset_quiet", 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
